riscv_alu_seq: RTL and testbench

Registered, handshaked ALU for the RISC-V unicycle datapath, parametrised in width. It keeps the existing 4-bit ALUctl opcode map and adds XOR, shifts and SLTU. It adds full NZCV flags and a sticky branch-zero flag with a synchronous clear. Operations are accepted with valid/ready and results are held until consumed, so the block can sit between decode and writeback in a pipelined core.

---
 rtl/riscv_alu_pkg.sv | 38 +++
 rtl/riscv_alu_seq_if.sv | 35 +++
 rtl/riscv_alu_mul_iter.sv | 54 +++++
 rtl/riscv_alu_seq.sv | 179 +++++++++++++++++
 tb/tb_riscv_alu_seq.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/riscv_alu_pkg.sv
// rtl/riscv_alu_pkg.sv - shared opcode, state and flag types for riscv_alu_seq
//
// Purpose: the ALUctl opcode map, the handshake FSM states and the NZCV flag
// bundle used by riscv_alu_seq and its testbench.
// Build option: RISCV_ALU_MUL_EN adds the ST_MUL state.
package riscv_alu_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,
    OP_OR   = 4'd1,
    OP_ADD  = 4'd2,
    OP_XOR  = 4'd3,
    OP_SLL  = 4'd4,
    OP_SRL  = 4'd5,
    OP_SUB  = 4'd6,
    OP_SLT  = 4'd7,
    OP_SLTU = 4'd8,
    OP_SRA  = 4'd9,
    OP_MUL  = 4'd10,
    OP_NOR  = 4'd12
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1
`ifdef RISCV_ALU_MUL_EN
    , ST_MUL = 2'd2
`endif
  } alu_state_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

endpackage

// File: rtl/riscv_alu_seq_if.sv
// rtl/riscv_alu_seq_if.sv - operation/result handshake bundle for riscv_alu_seq
//
// Purpose: groups the request side (in_valid/in_ready, alu_ctl, a, b), the
// result side (out_valid/out_ready, alu_out, flags, illegal_op) and the
// sticky branch-zero flag with its clear.
// Modports: master = producer/consumer driving operations, slave = the ALU.
interface riscv_alu_seq_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_ctl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_out;
  logic             flag_n;
  logic             flag_z;
  logic             flag_c;
  logic             flag_v;
  logic             illegal_op;
  logic             zero_sticky;
  logic             zero_clr;

  modport master (
    output in_valid, alu_ctl, a, b, out_ready, zero_clr,
    input  in_ready, out_valid, alu_out, flag_n, flag_z, flag_c, flag_v,
           illegal_op, zero_sticky
  );

  modport slave (
    input  in_valid, alu_ctl, a, b, out_ready, zero_clr,
    output in_ready, out_valid, alu_out, flag_n, flag_z, flag_c, flag_v,
           illegal_op, zero_sticky
  );
endinterface

// File: rtl/riscv_alu_mul_iter.sv
// rtl/riscv_alu_mul_iter.sv - iterative shift-add multiplier, low WIDTH bits
//
// Purpose: unsigned multiply over WIDTH cycles after a start pulse.
// Ports: clk, rst_n (async active-low), i_start (load operands),
//        i_a/i_b operands, o_done (last iteration this cycle),
//        o_result (valid while o_done is high).
module riscv_alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result
);
  localparam int CNT_W = $clog2(WIDTH);

  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic             r_busy;
  logic [WIDTH-1:0] w_acc_next;

  // The final partial product is folded in combinationally so the result is
  // ready in the WIDTH-th busy cycle rather than one cycle later.
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign o_done     = r_busy && (r_cnt == CNT_W'(WIDTH - 1));
  assign o_result   = w_acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_cnt    <= '0;
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (o_done) r_busy <= 1'b0;
    end
  end
endmodule

// File: rtl/riscv_alu_seq.sv
// rtl/riscv_alu_seq.sv - registered valid/ready RISC-V ALU with NZCV and sticky zero
//
// Purpose: accepts one operation per cycle, registers result, NZCV flags and
// illegal_op, and holds them until the consumer takes them.
// Ports: clk, reset_n (async active-low), bus (riscv_alu_seq_if.slave:
//        in_valid/in_ready/alu_ctl/a/b, out_valid/out_ready/alu_out,
//        flag_n/z/c/v, illegal_op, zero_sticky, zero_clr).
// Build option: RISCV_ALU_MUL_EN enables opcode 10 (iterative MUL).
module riscv_alu_seq
  import riscv_alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic           clk,
  input  logic           reset_n,
  riscv_alu_seq_if.slave bus
);
  alu_op_e            w_op;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [SHAMT_W-1:0] w_shamt;
  logic [WIDTH-1:0]   w_res;
  alu_flags_t         w_flags;
  logic               w_illegal;
  logic               w_is_mul;
  logic               w_sub_zero;

  alu_state_e         r_state;
  alu_state_e         w_next;
  alu_state_e         w_go;
  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_accept;
  logic               w_take_alu;

  logic [WIDTH-1:0]   r_result;
  alu_flags_t         r_flags;
  logic               r_illegal;
  logic               r_zero_sticky;

`ifdef RISCV_ALU_MUL_EN
  logic               w_mul_start;
  logic               w_mul_done;
  logic [WIDTH-1:0]   w_mul_result;

  riscv_alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk      (clk),
    .rst_n    (reset_n),
    .i_start  (w_mul_start),
    .i_a      (bus.a),
    .i_b      (bus.b),
    .o_done   (w_mul_done),
    .o_result (w_mul_result)
  );
`endif

  // Result and flag datapath
  always_comb begin
    w_op       = alu_op_e'(bus.alu_ctl);
    w_sum      = {1'b0, bus.a} + {1'b0, bus.b};
    // a + ~b + 1: the carry out is the inverted borrow
    w_diff     = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
    w_shamt    = bus.b[SHAMT_W-1:0];
    w_res      = '0;
    w_flags    = '0;
    w_illegal  = 1'b0;
    w_is_mul   = 1'b0;
    case (w_op)
      OP_AND:  w_res = bus.a & bus.b;
      OP_OR:   w_res = bus.a | bus.b;
      OP_XOR:  w_res = bus.a ^ bus.b;
      OP_NOR:  w_res = ~(bus.a | bus.b);
      OP_ADD: begin
        w_res     = w_sum[WIDTH-1:0];
        w_flags.c = w_sum[WIDTH];
        w_flags.v = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                    (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res     = w_diff[WIDTH-1:0];
        w_flags.c = w_diff[WIDTH];
        w_flags.v = (bus.a[WIDTH-1] == ~bus.b[WIDTH-1]) &&
                    (w_diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      OP_SLL:  w_res = bus.a << w_shamt;
      OP_SRL:  w_res = bus.a >> w_shamt;
      OP_SRA:  w_res = $unsigned($signed(bus.a) >>> w_shamt);
`ifdef RISCV_ALU_MUL_EN
      OP_MUL:  w_is_mul = 1'b1;
`endif
      default: w_illegal = 1'b1;
    endcase
    w_flags.n  = w_res[WIDTH-1];
    w_flags.z  = (w_res == '0);
    w_sub_zero = (w_op == OP_SUB) && (w_diff[WIDTH-1:0] == '0);
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // FSM next state and handshake outputs
  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
`ifdef RISCV_ALU_MUL_EN
    w_go        = w_is_mul ? ST_MUL : ST_HOLD;
`else
    w_go        = ST_HOLD;
`endif
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_next = w_go;
      end
      ST_HOLD: begin
        w_out_valid = 1'b1;
        // Consuming and accepting in the same cycle keeps one result per cycle
        w_in_ready  = bus.out_ready;
        if (bus.out_ready) w_next = bus.in_valid ? w_go : ST_IDLE;
      end
`ifdef RISCV_ALU_MUL_EN
      ST_MUL: begin
        if (w_mul_done) w_next = ST_HOLD;
      end
`endif
      default: w_next = ST_IDLE;
    endcase
    w_accept   = bus.in_valid & w_in_ready;
    w_take_alu = w_accept & ~w_is_mul;
  end

`ifdef RISCV_ALU_MUL_EN
  assign w_mul_start = w_accept & w_is_mul;
`endif

  // Result, flags and sticky zero; these keep their value after consumption
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_result      <= '0;
      r_flags       <= '0;
      r_illegal     <= 1'b0;
      r_zero_sticky <= 1'b0;
    end else begin
      if (w_take_alu) begin
        r_result  <= w_res;
        r_flags   <= w_flags;
        r_illegal <= w_illegal;
      end
`ifdef RISCV_ALU_MUL_EN
      else if (w_mul_done) begin
        r_result  <= w_mul_result;
        r_flags   <= '{n: w_mul_result[WIDTH-1], z: (w_mul_result == '0),
                       c: 1'b0, v: 1'b0};
        r_illegal <= 1'b0;
      end
`endif
      // Set has priority over the clear
      if (w_accept && w_sub_zero) r_zero_sticky <= 1'b1;
      else if (bus.zero_clr)      r_zero_sticky <= 1'b0;
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = w_out_valid;
  assign bus.alu_out     = r_result;
  assign bus.flag_n      = r_flags.n;
  assign bus.flag_z      = r_flags.z;
  assign bus.flag_c      = r_flags.c;
  assign bus.flag_v      = r_flags.v;
  assign bus.illegal_op  = r_illegal;
  assign bus.zero_sticky = r_zero_sticky;
endmodule

// File: tb/tb_riscv_alu_seq.sv
// tb/tb_riscv_alu_seq.sv - scoreboard testbench for riscv_alu_seq
module tb_riscv_alu_seq;
  import riscv_alu_pkg::*;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] res;
    logic [3:0]   nzcv;
    logic         ill;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_vec = 0;
  int   n_miss = 0;
  int   cyc = 0;
  int   last_acc = 0;
  int   c1, c2, c3;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  riscv_alu_seq_if #(.WIDTH(W)) bus();

  riscv_alu_seq #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Monitor: compare each consumed result against the scoreboard head
  always @(negedge clk) begin
    if (reset_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_result: got %0h with empty scoreboard", bus.alu_out);
      end else begin
        mon_e = sb.pop_front();
        check("alu_out", bus.alu_out, mon_e.res);
        check("nzcv", {bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v}, mon_e.nzcv);
        check("illegal_op", bus.illegal_op, mon_e.ill);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge
  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] r, input logic [3:0] nzcv, input logic ill);
    int waited = 0;
    bus.in_valid = 1'b1;
    bus.alu_ctl  = op;
    bus.a        = a;
    bus.b        = b;
    @(negedge clk);
    while (!bus.in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("accept", bus.in_ready, 1'b1);
    sb.push_back('{res: r, nzcv: nzcv, ill: ill});
    @(posedge clk);
    #1;
    last_acc = cyc;
    bus.in_valid = 1'b0;
`ifdef RISCV_ALU_MUL_EN
    if (op == 4'd10) begin
      int bad = 0;
      for (int i = 0; i < W; i++) begin
        if (bus.out_valid || bus.in_ready) bad++;
        @(posedge clk);
        #1;
      end
      check("mul_busy", bad, 0);
      check("mul_latency", bus.out_valid, 1'b1);
    end else
`endif
    check("latency1", bus.out_valid, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.alu_ctl   = 4'd0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    bus.zero_clr  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_alu_out", bus.alu_out, 0);
    check("rst_flags", {bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v}, 4'b0000);
    check("rst_illegal", bus.illegal_op, 1'b0);
    check("rst_sticky", bus.zero_sticky, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Arithmetic and sticky zero
    send(4'd2, 32'h7FFFFFFF, 32'h1, 32'h80000000, 4'b1001, 1'b0);
    send(4'd6, 32'd5, 32'd5, 32'h0, 4'b0110, 1'b0);
    check("sticky_set", bus.zero_sticky, 1'b1);
    send(4'd2, 32'd1, 32'd1, 32'd2, 4'b0000, 1'b0);
    check("sticky_hold", bus.zero_sticky, 1'b1);
    bus.zero_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.zero_clr = 1'b0;
    check("sticky_clr", bus.zero_sticky, 1'b0);
    bus.zero_clr = 1'b1;
    send(4'd6, 32'd5, 32'd5, 32'h0, 4'b0110, 1'b0);
    bus.zero_clr = 1'b0;
    check("sticky_set_wins", bus.zero_sticky, 1'b1);
    bus.zero_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.zero_clr = 1'b0;
    send(4'd6, 32'd0, 32'd1, 32'hFFFFFFFF, 4'b1000, 1'b0);
    send(4'd6, 32'h80000000, 32'd1, 32'h7FFFFFFF, 4'b0011, 1'b0);
    send(4'd2, 32'hFFFFFFFF, 32'd1, 32'h0, 4'b0110, 1'b0);
    check("sticky_add_zero", bus.zero_sticky, 1'b0);

    // Back-to-back throughput, then backpressure
    send(4'd7, 32'hFFFFFFFF, 32'd1, 32'd1, 4'b0000, 1'b0);
    c1 = last_acc;
    send(4'd8, 32'hFFFFFFFF, 32'd1, 32'd0, 4'b0100, 1'b0);
    c2 = last_acc;
    send(4'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b1000, 1'b0);
    c3 = last_acc;
    bus.out_ready = 1'b0;
    check("b2b_gap1", c2 - c1, 1);
    check("b2b_gap2", c3 - c2, 1);
    repeat (2) @(posedge clk);
    #1;
    check("hold_out_valid", bus.out_valid, 1'b1);
    check("hold_in_ready", bus.in_ready, 1'b0);
    check("hold_alu_out", bus.alu_out, 32'hF000F000);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("idle_after_consume", bus.out_valid, 1'b0);

    // Shifts and logic
    send(4'd9, 32'h80000000, 32'h00000024, 32'hF8000000, 4'b1000, 1'b0);
    send(4'd5, 32'h80000000, 32'h00000024, 32'h08000000, 4'b0000, 1'b0);
    send(4'd4, 32'h00000001, 32'h0000003F, 32'h80000000, 4'b1000, 1'b0);
    send(4'd3, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0, 4'b0100, 1'b0);
    send(4'd12, 32'h0, 32'h0, 32'hFFFFFFFF, 4'b1000, 1'b0);

    // Illegal opcodes, then a legal op clears illegal_op
    send(4'd15, 32'd1, 32'd2, 32'h0, 4'b0100, 1'b1);
    send(4'd11, 32'd3, 32'd4, 32'h0, 4'b0100, 1'b1);
    send(4'd1, 32'h12, 32'h21, 32'h33, 4'b0000, 1'b0);

`ifdef RISCV_ALU_MUL_EN
    send(4'd10, 32'd12345, 32'd678, 32'd8369910, 4'b0000, 1'b0);
`else
    send(4'd10, 32'd12345, 32'd678, 32'h0, 4'b0100, 1'b1);
`endif
    @(posedge clk);
    #1;

    // Asynchronous reset while a result is held
    bus.out_ready = 1'b0;
    send(4'd6, 32'd5, 32'd5, 32'h0, 4'b0110, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_out_valid", bus.out_valid, 1'b0);
    check("arst_alu_out", bus.alu_out, 0);
    check("arst_sticky", bus.zero_sticky, 1'b0);
    check("arst_in_ready", bus.in_ready, 1'b1);
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
